// File: rtl/and_share_arbiter_pkg.sv
// Shared types and constants for the shared AND arbiter: ID width helper,
// output-slot state encoding and completion counter width.
package and_share_arbiter_pkg;

    localparam int DONE_CNT_W = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    // Never narrower than one bit so a 1-requester build still has a legal ID port.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/and_db.sv
// Single-bit AND gate used once per operand bit in the shared datapath.
// Purely combinational, no flow control.
module and_db (
    input  logic a,
    input  logic b,
    output logic z
);

    assign z = a & b;

endmodule

// File: rtl/and_share_arbiter_rr_grant.sv
// Round-robin one-hot grant starting after the last served requester.
// Purely combinational; grant is zero when no request is present.
module rr_grant
    import and_share_arbiter_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic found;
    int   pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        // Visit last+1 .. last+N so the previous winner is considered last.
        for (int k = 1; k <= N; k++) begin
            pos = (int'(last) + k) % N;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/and_share_arbiter.sv
// Shares one registered bitwise-AND datapath among NUM_REQ valid/ready requesters.
// One cycle transfer-to-result latency; a stalled output slot blocks all grants.
module and_share_arbiter
    import and_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    localparam int ID_W   = id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_x,
    input  logic [NUM_REQ*WIDTH-1:0] req_y,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_z,
    output logic [ID_W-1:0]          rsp_id,
    output logic [DONE_CNT_W-1:0]    done_cnt
);

    slot_state_t     state;
    logic [ID_W-1:0] last;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0] gidx;
    logic            accept;
    logic            xfer;
    logic            drain;

    logic [WIDTH-1:0] xs [NUM_REQ];
    logic [WIDTH-1:0] ys [NUM_REQ];
    logic [WIDTH-1:0] x_sel;
    logic [WIDTH-1:0] y_sel;
    logic [WIDTH-1:0] z_and;

    rr_grant #(.N(NUM_REQ)) u_rr_grant (
        .req   (req_valid),
        .last  (last),
        .grant (grant),
        .idx   (gidx)
    );

    assign rsp_valid = (state == FULL);
    // Slot can take a new result when empty or when it drains this very cycle.
    assign accept    = !rsp_valid || rsp_ready;
    assign req_ready = grant & {NUM_REQ{accept}};
    assign xfer      = |req_ready;
    assign drain     = rsp_valid && rsp_ready;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign xs[i] = req_x[i*WIDTH +: WIDTH];
        assign ys[i] = req_y[i*WIDTH +: WIDTH];
    end

    assign x_sel = xs[gidx];
    assign y_sel = ys[gidx];

    for (genvar b = 0; b < WIDTH; b++) begin : g_and
        and_db u_and_db (
            .a (x_sel[b]),
            .b (y_sel[b]),
            .z (z_and[b])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            rsp_z    <= '0;
            rsp_id   <= '0;
            last     <= ID_W'(NUM_REQ - 1);
            done_cnt <= '0;
        end else begin
            if (drain) begin
                done_cnt <= done_cnt + 1'b1;
            end
            if (xfer) begin
                state  <= FULL;
                rsp_z  <= z_and;
                rsp_id <= gidx;
                last   <= gidx;
            end else if (drain) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_and_share_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model of the shared AND arbiter.
module tb_and_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_x;
    logic [N*W-1:0] req_y;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_z;
    logic [IW-1:0]  rsp_id;
    logic [15:0]    done_cnt;

    logic [W-1:0] xa [N];
    logic [W-1:0] ya [N];

    int n_checks = 0;
    int n_errors = 0;

    // Model of the observable state.
    bit     m_valid;
    int     m_z;
    int     m_id;
    int     m_last;
    int     m_cnt;
    int     last_g;

    and_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_id    (rsp_id),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner is the valid requester at the smallest circular distance after 'last'.
    function automatic int exp_grant(input logic [N-1:0] v, input int last);
        int best;
        int bd;
        int d;
        best = -1;
        bd   = N;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                d = (i - last - 1 + N) % N;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_z     = 0;
        m_id    = 0;
        m_last  = N - 1;
        m_cnt   = 0;
    endtask

    // Inputs are already set (posedge+1); check mid-cycle, then advance one edge.
    task automatic cycle();
        int g;
        logic [N-1:0] er;
        for (int i = 0; i < N; i++) begin
            req_x[i*W +: W] = xa[i];
            req_y[i*W +: W] = ya[i];
        end
        @(negedge clk);
        g  = (!m_valid || rsp_ready) ? exp_grant(req_valid, m_last) : -1;
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("rsp_z",     32'(rsp_z),     32'(m_z));
        chk("rsp_id",    32'(rsp_id),    32'(m_id));
        chk("done_cnt",  32'(done_cnt),  32'(m_cnt));
        @(posedge clk);
        last_g = g;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_valid && rsp_ready) m_cnt = (m_cnt + 1) & 16'hFFFF;
            if (g >= 0) begin
                m_valid = 1'b1;
                m_z     = int'(xa[g] & ya[g]);
                m_id    = g;
                m_last  = g;
            end else if (m_valid && rsp_ready) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        req_x     = '0;
        req_y     = '0;
        for (int i = 0; i < N; i++) begin
            xa[i] = '0;
            ya[i] = '0;
        end
        last_g = -1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;

        // Reset state
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_z",     32'(rsp_z),     32'd0);
        chk("rst_id",    32'(rsp_id),    32'd0);
        chk("rst_cnt",   32'(done_cnt),  32'd0);

        // Single request from requester 1
        req_valid = 4'b0010;
        xa[1] = 4'hB;
        ya[1] = 4'h6;
        cycle();
        chk("single_vld", 32'(rsp_valid), 32'd1);
        chk("single_z",   32'(rsp_z),     32'h2);
        chk("single_id",  32'(rsp_id),    32'd1);
        req_valid = '0;
        cycle();
        chk("single_cnt",   32'(done_cnt),  32'd1);
        chk("single_drain", 32'(rsp_valid), 32'd0);

        // Fair rotation after reset
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rot_id", 32'(rsp_id), 32'(k % N));
        end
        req_valid = '0;
        cycle();
        chk("rot_cnt", 32'(done_cnt), 32'd8);

        // Backpressure with x=F, y=9 held in the slot
        do_reset();
        xa[0] = 4'hF;
        ya[0] = 4'h9;
        req_valid = 4'b0001;
        cycle();
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_z",     32'(rsp_z),     32'h9);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume", 32'(req_ready), 32'b0010);
        @(posedge clk);
        #1;
        m_cnt   = 1;
        m_z     = int'(xa[1] & ya[1]);
        m_id    = 1;
        m_last  = 1;
        req_valid = '0;
        cycle();

        // Truth-table sweep on requester 2
        for (int k = 0; k < 4; k++) begin
            xa[2] = (k >= 2) ? 4'hF : 4'h0;
            ya[2] = (k % 2 == 1) ? 4'hF : 4'h0;
            req_valid = 4'b0100;
            cycle();
            chk("tt_z",  32'(rsp_z),  (k == 3) ? 32'hF : 32'h0);
            chk("tt_id", 32'(rsp_id), 32'd2);
        end
        req_valid = '0;
        cycle();

        // Reset while a result is held under backpressure
        req_valid = 4'b1000;
        cycle();
        rsp_ready = 1'b0;
        req_valid = '0;
        cycle();
        chk("mid_held", 32'(rsp_valid), 32'd1);
        do_reset();
        chk("mid_vld", 32'(rsp_valid), 32'd0);
        chk("mid_cnt", 32'(done_cnt),  32'd0);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        cycle();
        chk("mid_grant0", 32'(last_g), 32'd0);
        req_valid = '0;
        cycle();

        // Counter wrap via back-to-back responses
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 65536; k++) cycle();
        chk("wrap_ffff", 32'(done_cnt), 32'hFFFF);
        cycle();
        chk("wrap_zero", 32'(done_cnt),  32'h0);
        chk("wrap_vld",  32'(rsp_valid), 32'd1);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            rst_n     = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < N; i++) begin
                xa[i] = W'($urandom);
                ya[i] = W'($urandom);
            end
            cycle();
        end
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
